// File: rtl/ctrl_alarma_temp_pkg.sv
// ctrl_alarma_temp_pkg: state codes and counter-width helper shared by the
// temperature alarm controller and its testbench.
package ctrl_alarma_temp_pkg;

    typedef enum logic [1:0] {
        REPOSO     = 2'b00,
        VALIDANDO  = 2'b01,
        ALARMA     = 2'b10,
        SILENCIADO = 2'b11
    } estado_t;

    // Never returns zero, so a parameter of 1 still yields a legal vector.
    function automatic int ancho(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ctrl_alarma_temp_sincronizador.sv
// sincronizador: two-flop synchroniser for an asynchronous level, reset to 0.
module sincronizador (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_q, s2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/ctrl_alarma_temp.sv
// ctrl_alarma_temp: filters the preventive temperature flag, confirms a sustained
// over-temperature, drives buzzer and blinking LED, and mutes on acknowledge.
module ctrl_alarma_temp
    import ctrl_alarma_temp_pkg::*;
#(
    parameter int FILTRO          = 4,
    parameter int PERIODO         = 8,
    parameter int TIEMPO_SILENCIO = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       temp_preven,
    input  logic       boton_ack,
    output logic       buzzer,
    output logic       led_alarma,
    output logic       alarma_activa,
    output logic [1:0] estado
);

    localparam int CW = ancho(FILTRO);
    localparam int PW = ancho(PERIODO);
    localparam int TW = ancho(TIEMPO_SILENCIO);
    localparam logic [CW-1:0] F_MAX = CW'(FILTRO - 1);
    localparam logic [PW-1:0] P_MAX = PW'(PERIODO - 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIEMPO_SILENCIO - 1);

    logic t_s, a_s, ack_p;
    logic a_s_d_q, a_s_d_d;
    estado_t estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] parp_q, parp_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic buzzer_q, buzzer_d, led_q, led_d, activa_q, activa_d;

    sincronizador u_sinc_temp (.clk(clk), .reset(reset), .d(temp_preven), .q(t_s));
    sincronizador u_sinc_ack  (.clk(clk), .reset(reset), .d(boton_ack),   .q(a_s));

    assign ack_p = a_s & ~a_s_d_q;

    // Outputs are derived from the next state so they are registered with it.
    always_comb begin
        a_s_d_d  = a_s;
        estado_d = estado_q;
        cnt_d    = cnt_q;
        parp_d   = '0;
        tmr_d    = '0;
        led_d    = 1'b0;
        case (estado_q)
            REPOSO: begin
                if (t_s) begin
                    estado_d = VALIDANDO;
                    cnt_d    = CW'(1);
                end
            end
            VALIDANDO: begin
                if (!t_s) begin
                    estado_d = REPOSO;
                    cnt_d    = '0;
                end else if (cnt_q == F_MAX) begin
                    estado_d = ALARMA;
                    cnt_d    = '0;
                    led_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ALARMA: begin
                // Clear completion outranks a simultaneous acknowledge.
                if (!t_s && cnt_q == F_MAX) begin
                    estado_d = REPOSO;
                    cnt_d    = '0;
                end else if (ack_p) begin
                    estado_d = SILENCIADO;
                    cnt_d    = '0;
                    led_d    = 1'b1;
                end else begin
                    cnt_d  = t_s ? '0 : cnt_q + 1'b1;
                    parp_d = (parp_q == P_MAX) ? '0 : parp_q + 1'b1;
                    led_d  = (parp_q == P_MAX) ? ~led_q : led_q;
                end
            end
            SILENCIADO: begin
                led_d = 1'b1;
                if (tmr_q == T_MAX) begin
                    if (t_s) estado_d = ALARMA;
                    else     estado_d = REPOSO;
                    led_d = t_s;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
        endcase
        buzzer_d = (estado_d == ALARMA);
        activa_d = (estado_d == ALARMA) || (estado_d == SILENCIADO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_s_d_q  <= 1'b0;
            estado_q <= REPOSO;
            cnt_q    <= '0;
            parp_q   <= '0;
            tmr_q    <= '0;
            buzzer_q <= 1'b0;
            led_q    <= 1'b0;
            activa_q <= 1'b0;
        end else begin
            a_s_d_q  <= a_s_d_d;
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            parp_q   <= parp_d;
            tmr_q    <= tmr_d;
            buzzer_q <= buzzer_d;
            led_q    <= led_d;
            activa_q <= activa_d;
        end
    end

    assign estado        = estado_q;
    assign buzzer        = buzzer_q;
    assign led_alarma    = led_q;
    assign alarma_activa = activa_q;

endmodule
